// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: funct codes, FSM state type,
// and a helper that classifies the single-bit shift operations.
package alu_pkg;

  localparam logic [3:0] F_ADD = 4'd0;
  localparam logic [3:0] F_SUB = 4'd1;
  localparam logic [3:0] F_AND = 4'd2;
  localparam logic [3:0] F_OR  = 4'd3;
  localparam logic [3:0] F_XOR = 4'd4;
  localparam logic [3:0] F_NOT = 4'd5;
  localparam logic [3:0] F_SLA = 4'd6;
  localparam logic [3:0] F_SRA = 4'd7;
  localparam logic [3:0] F_SRL = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  // Shift ops are executed as repeated one-bit ALU passes.
  function automatic logic is_shift(input logic [3:0] op);
    return (op == F_SLA) || (op == F_SRA) || (op == F_SRL);
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Command-side driver for an external combinational ALU. One command per
// handshake; shifts by N are run as N single-bit passes (amount 0 = one pass
// with B=0). Optional feature macro: ALU_SEQ_ILLEGAL_OP_EN (funct > 8 is
// rejected with rsp_err instead of being passed to the ALU).
//
// Handshake rules: a transfer happens on a rising clk edge where valid and
// ready are both high. cmd_ready is high only in IDLE. Once rsp_valid rises,
// it and all rsp_* fields hold steady until the rsp_ready handshake.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [3:0]         cmd_op,
  input  logic [DATA_W-1:0]  cmd_a,
  input  logic [DATA_W-1:0]  cmd_b,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [3:0]         alu_funct,
  input  logic [DATA_W-1:0]  alu_out,
  input  logic               alu_zero,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_data,
  output logic               rsp_zero,
  output logic               rsp_err,
  output logic [SHAMT_W:0]   rsp_passes,
  output logic [1:0]         dbg_state
);

  localparam int CNT_W = SHAMT_W + 1;

  seq_state_e          state, state_nxt;
  logic [DATA_W-1:0]   acc, opb;
  logic [3:0]          op;
  logic [CNT_W-1:0]    n_left, passes, n_init;
  logic                zero_q;
  logic                accept;
  logic [SHAMT_W-1:0]  cmd_amt;

  assign accept    = cmd_valid && (state == ST_IDLE);
  assign cmd_amt   = cmd_b[SHAMT_W-1:0];
  assign dbg_state = state;

  assign rsp_data   = acc;
  assign rsp_zero   = zero_q;
  assign rsp_passes = passes;

`ifdef ALU_SEQ_ILLEGAL_OP_EN
  logic err_q;
  logic op_illegal;
  assign op_illegal = (cmd_op > F_SRL);
  assign rsp_err    = err_q;
`else
  assign rsp_err    = 1'b0;
`endif

  // Pass count for a new command: shift amount (minimum one), else a single pass.
  always_comb begin
    n_init = CNT_W'(1);
    if (is_shift(cmd_op) && (cmd_amt != '0)) n_init = {1'b0, cmd_amt};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode plus handshake and ALU drive outputs.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_funct = 4'd0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_nxt = ST_EXEC;
`ifdef ALU_SEQ_ILLEGAL_OP_EN
          if (op_illegal) state_nxt = ST_DONE;
`endif
        end
      end
      ST_EXEC: begin
        alu_a     = acc;
        alu_funct = op;
        if (is_shift(op)) alu_b = {{(DATA_W-1){1'b0}}, (opb[SHAMT_W-1:0] != '0)};
        else              alu_b = opb;
        if (n_left == CNT_W'(1)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand latch on accept, accumulate one ALU pass per EXEC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      opb    <= '0;
      op     <= 4'd0;
      n_left <= '0;
      passes <= '0;
      zero_q <= 1'b0;
`ifdef ALU_SEQ_ILLEGAL_OP_EN
      err_q  <= 1'b0;
`endif
    end else if (accept) begin
      acc    <= cmd_a;
      opb    <= cmd_b;
      op     <= cmd_op;
      n_left <= n_init;
      passes <= n_init;
      zero_q <= 1'b0;
`ifdef ALU_SEQ_ILLEGAL_OP_EN
      err_q  <= 1'b0;
      if (op_illegal) begin
        acc    <= '0;
        zero_q <= 1'b1;
        err_q  <= 1'b1;
        passes <= '0;
        n_left <= '0;
      end
`endif
    end else if (state == ST_EXEC) begin
      acc    <= alu_out;
      zero_q <= alu_zero;
      n_left <= n_left - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU attached.
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_a, cmd_b;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_funct;
  logic        alu_zero;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_zero, rsp_err;
  logic [5:0]  rsp_passes;
  logic [1:0]  dbg_state;

  int n_vec  = 0;
  int n_miss = 0;
  logic [31:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DATA_W(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_funct(alu_funct),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err), .rsp_passes(rsp_passes),
    .dbg_state(dbg_state)
  );

  // External one-bit-shift ALU.
  always_comb begin
    case (alu_funct)
      4'd0:    alu_out = alu_a + alu_b;
      4'd1:    alu_out = alu_a - alu_b;
      4'd2:    alu_out = alu_a & alu_b;
      4'd3:    alu_out = alu_a | alu_b;
      4'd4:    alu_out = alu_a ^ alu_b;
      4'd5:    alu_out = ~alu_a;
      4'd6:    alu_out = alu_a << alu_b[0];
      4'd7:    alu_out = $unsigned($signed(alu_a) >>> alu_b[0]);
      4'd8:    alu_out = alu_a >> alu_b[0];
      default: alu_out = 32'd0;
    endcase
  end
  assign alu_zero = (alu_out == 32'd0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present a command and return just after the accepting edge.
  task automatic drive_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int waited;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = op; cmd_a = a; cmd_b = b;
    waited = 0;
    while (!cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) check("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Count cycles to rsp_valid (accept cycle = 0); check alu_b and cmd_ready meanwhile.
  task automatic wait_rsp(input string tag, input logic [31:0] exp_b, input int exp_lat);
    int lat, b_ok, rdy_hi;
    lat = 0; b_ok = 0; rdy_hi = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!rsp_valid) begin
        if (alu_b === exp_b) b_ok++;
        if (cmd_ready) rdy_hi++;
      end
    end while (!rsp_valid && lat < 200);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_alu_b"}, b_ok, exp_lat - 1);
    check({tag, "_busy_ready"}, rdy_hi, 32'd0);
  endtask

  // Hold rsp_ready low for 'hold' cycles, then check the response and hand it off.
  task automatic take_rsp(input string tag, input logic exp_zero, input logic exp_err,
                          input logic [5:0] exp_passes, input int hold);
    logic [31:0] exp_data, d0;
    logic [7:0] f0;
    int unstable, rdy_hi;
    exp_data = exp_q.pop_front();
    d0 = rsp_data;
    f0 = {rsp_valid, rsp_zero, rsp_err, rsp_passes[4:0]};
    unstable = 0; rdy_hi = 0;
    repeat (hold) begin
      @(negedge clk);
      if (rsp_data !== d0 || {rsp_valid, rsp_zero, rsp_err, rsp_passes[4:0]} !== f0) unstable++;
      if (cmd_ready) rdy_hi++;
    end
    if (hold > 0) begin
      check({tag, "_hold_stable"}, unstable, 32'd0);
      check({tag, "_hold_ready"}, rdy_hi, 32'd0);
    end
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_data"}, rsp_data, exp_data);
    check({tag, "_zero"}, 32'(rsp_zero), 32'(exp_zero));
    check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    check({tag, "_passes"}, 32'(rsp_passes), 32'(exp_passes));
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_data, input logic exp_zero,
                        input logic [5:0] exp_passes, input logic [31:0] exp_b);
    exp_q.push_back(exp_data);
    drive_cmd(op, a, b);
    wait_rsp(tag, exp_b, int'(exp_passes) + 1);
    take_rsp(tag, exp_zero, 1'b0, exp_passes, 0);
  endtask

  initial begin
    int spurious;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_a = 32'd0; cmd_b = 32'd0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_data", rsp_data, 32'd0);
    check("reset_alu_funct", 32'(alu_funct), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;

    run_op("add",   4'd0, 32'd5, 32'd7, 32'd12, 1'b0, 6'd1, 32'd7);
    run_op("sub",   4'd1, 32'd9, 32'd9, 32'd0,  1'b1, 6'd1, 32'd9);
    run_op("sra31", 4'd7, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 6'd31, 32'd1);
    run_op("sla0",  4'd6, 32'd1, 32'h20, 32'd1, 1'b0, 6'd1, 32'd0);
    run_op("sla31", 4'd6, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 6'd31, 32'd1);
    run_op("srl4",  4'd8, 32'hF0, 32'h104, 32'h0F, 1'b0, 6'd4, 32'd1);
    run_op("and",   4'd2, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b0, 6'd1, 32'h0F0F_0F0F);
    run_op("xor",   4'd4, 32'h1234_5678, 32'h1234_5678, 32'd0, 1'b1, 6'd1, 32'h1234_5678);
    run_op("not",   4'd5, 32'd0, 32'd123, 32'hFFFF_FFFF, 1'b0, 6'd1, 32'd123);

    // Backpressure with a queued command waiting behind the response.
    exp_q.push_back(32'hFF);
    drive_cmd(4'd3, 32'hF0, 32'h0F);
    wait_rsp("or_bp", 32'h0F, 2);
    cmd_valid = 1'b1; cmd_op = 4'd0; cmd_a = 32'd1; cmd_b = 32'd1;
    take_rsp("or_bp", 1'b0, 1'b0, 6'd1, 5);
    @(negedge clk);
    check("queued_ready_after_rsp", 32'(cmd_ready), 32'd1);
    exp_q.push_back(32'd2);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_rsp("queued_add", 32'd1, 2);
    take_rsp("queued_add", 1'b0, 1'b0, 6'd1, 0);

    // Reset in the third EXEC cycle of a long shift.
    drive_cmd(4'd8, 32'hFFFF_0000, 32'd20);
    repeat (3) @(negedge clk);
    check("pre_reset_state", 32'(dbg_state), 32'd1);
    rst = 1'b1;
    cmd_valid = 1'b1; cmd_op = 4'd0; cmd_a = 32'd2; cmd_b = 32'd2;
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_passes", 32'(rsp_passes), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_funct", 32'(alu_funct), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b0;
    rst = 1'b0;
    spurious = 0;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid) spurious++;
    end
    check("rst_no_response", spurious, 32'd0);
    run_op("post_rst_add", 4'd0, 32'd3, 32'd4, 32'd7, 1'b0, 6'd1, 32'd4);

    // Illegal funct code.
    exp_q.push_back(32'd0);
    drive_cmd(4'hC, 32'd5, 32'd6);
`ifdef ALU_SEQ_ILLEGAL_OP_EN
    wait_rsp("illegal", 32'd0, 1);
    take_rsp("illegal", 1'b1, 1'b1, 6'd0, 0);
`else
    wait_rsp("illegal", 32'd6, 2);
    take_rsp("illegal", 1'b1, 1'b0, 6'd1, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
